// File: rtl/ws2812_multi_timing_apb.sv
// APB-controlled WS2812/SK6812 chain driver with indexed colour RAM, queued re-send and output invert.
// Define WS2812_BRIGHTNESS_EN to add a global brightness register applied to each pixel at load time.
module ws2812_multi_timing_apb #(
  parameter int LED_COUNT       = 8,
  parameter int BITS_PER_LED    = 24,
  parameter int CLOCK_FREQUENCY = 38000000,
  parameter int T0H_NS          = 350,
  parameter int T1H_NS          = 700,
  parameter int BIT_NS          = 1250,
  parameter int RESET_US        = 80
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  output logic        led_ctl_o,
  output logic        int_o,
  input  logic        apb_psel_i,
  input  logic        apb_penable_i,
  input  logic        apb_pwrite_i,
  input  logic [5:0]  apb_paddr_i,
  input  logic [31:0] apb_pwdata_i,
  output logic [31:0] apb_prdata_o,
  output logic        apb_pready_o,
  output logic        apb_pslverr_o
);

  localparam int T0H_CYC   = (CLOCK_FREQUENCY / 1000) * T0H_NS / 1000000;
  localparam int T1H_CYC   = (CLOCK_FREQUENCY / 1000) * T1H_NS / 1000000;
  localparam int BIT_CYC   = (CLOCK_FREQUENCY / 1000) * BIT_NS / 1000000;
  localparam int RESET_CYC = (CLOCK_FREQUENCY / 1000000) * RESET_US;

  localparam int AW      = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
  localparam int DEPTH   = 1 << AW;
  localparam int MAX_CYC = (RESET_CYC > BIT_CYC) ? RESET_CYC : BIT_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
`ifdef WS2812_BRIGHTNESS_EN
  localparam int LOAD_CYC = 2;
`else
  localparam int LOAD_CYC = 1;
`endif

  localparam logic [AW-1:0] LAST_PIXEL   = AW'(LED_COUNT - 1);
  localparam logic [31:0]   LED_LIMIT    = LED_COUNT;
  localparam logic [CW-1:0] T0H_LAST     = CW'(T0H_CYC - 1);
  localparam logic [CW-1:0] T1H_LAST     = CW'(T1H_CYC - 1);
  localparam logic [CW-1:0] BIT_LAST     = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] BIT_LAST_PIX = CW'(BIT_CYC - 1 - LOAD_CYC);
  localparam logic [CW-1:0] GAP_LAST     = CW'(RESET_CYC - 1);

  localparam logic [2:0] TX_IDLE  = 3'd0;
  localparam logic [2:0] TX_LOAD  = 3'd1;
`ifdef WS2812_BRIGHTNESS_EN
  localparam logic [2:0] TX_SCALE = 3'd2;
`endif
  localparam logic [2:0] TX_HIGH  = 3'd3;
  localparam logic [2:0] TX_LOW   = 3'd4;
  localparam logic [2:0] TX_GAP   = 3'd5;

  localparam logic [1:0] BUS_IDLE    = 2'd0;
  localparam logic [1:0] BUS_RESP    = 2'd1;
  localparam logic [1:0] BUS_RECOVER = 2'd2;

  if ((BITS_PER_LED != 24 && BITS_PER_LED != 32) || LED_COUNT < 1 || LED_COUNT > 256) begin : g_param_check
    $error("ws2812_multi_timing_apb: BITS_PER_LED must be 24 or 32 and LED_COUNT 1..256");
  end

  logic [BITS_PER_LED-1:0] colour [DEPTH];

  logic [1:0]              bus_state;
  logic                    auto_send;
  logic                    int_enable;
  logic                    invert;
  logic [AW-1:0]           index;
  logic                    pending;
  logic                    sending;
  logic [2:0]              tx_state;
  logic [AW-1:0]           pixel;
  logic [BITS_PER_LED-1:0] shift;
  logic [5:0]              bits_left;
  logic [CW-1:0]           cnt;

  logic                    access;
  logic [31:0]             rdata_next;
  logic                    err_next;
  logic                    set_pending;
  logic                    ram_we;
  logic                    index_step;
  logic                    index_load;
  logic                    ctrl_we;

`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0] brightness;
  logic       bright_we;

  // Each byte becomes (byte * (level + 1)) >> 8, so 0xFF is transparent.
  function automatic logic [BITS_PER_LED-1:0] scale(input logic [BITS_PER_LED-1:0] px,
                                                    input logic [7:0] level);
    logic [BITS_PER_LED-1:0] res;
    logic [15:0]             prod;
    res = '0;
    for (int i = 0; i < BITS_PER_LED / 8; i++) begin
      prod = 16'(px[i*8 +: 8]) * (16'(level) + 16'd1);
      res[i*8 +: 8] = prod[15:8];
    end
    return res;
  endfunction
`endif

  assign access        = apb_psel_i & apb_penable_i & (bus_state == BUS_IDLE);
  assign led_ctl_o     = (tx_state == TX_HIGH) ^ invert;

  always_comb begin
    rdata_next  = '0;
    err_next    = 1'b0;
    set_pending = 1'b0;
    ram_we      = 1'b0;
    index_step  = 1'b0;
    index_load  = 1'b0;
    ctrl_we     = 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
    bright_we   = 1'b0;
`endif
    if (access) begin
      case (apb_paddr_i)
        6'h00: begin
          if (apb_pwrite_i) err_next = 1'b1;
          else              rdata_next = {30'd0, pending, sending};
        end
        6'h04: begin
          if (apb_pwrite_i) begin
            ctrl_we     = 1'b1;
            set_pending = apb_pwdata_i[1];
          end else begin
            rdata_next = {28'd0, invert, int_enable, 1'b0, auto_send};
          end
        end
        6'h08: begin
          if (apb_pwrite_i) begin
            if (apb_pwdata_i < LED_LIMIT) index_load = 1'b1;
            else                          err_next   = 1'b1;
          end else begin
            rdata_next = 32'(index);
          end
        end
        6'h0C: begin
          index_step = 1'b1;
          if (apb_pwrite_i) begin
            ram_we      = 1'b1;
            set_pending = auto_send;
          end else begin
            rdata_next = 32'(colour[index]);
          end
        end
`ifdef WS2812_BRIGHTNESS_EN
        6'h10: begin
          if (apb_pwrite_i) bright_we  = 1'b1;
          else              rdata_next = {24'd0, brightness};
        end
`endif
        default: err_next = 1'b1;
      endcase
    end
  end

  // Bus handshake: accept, one response cycle, one recovery cycle.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      bus_state     <= BUS_IDLE;
      apb_prdata_o  <= '0;
      apb_pready_o  <= 1'b0;
      apb_pslverr_o <= 1'b0;
      auto_send     <= 1'b1;
      int_enable    <= 1'b0;
      invert        <= 1'b0;
      index         <= '0;
`ifdef WS2812_BRIGHTNESS_EN
      brightness    <= 8'hFF;
`endif
    end else begin
      case (bus_state)
        BUS_IDLE: begin
          if (access) begin
            bus_state     <= BUS_RESP;
            apb_pready_o  <= 1'b1;
            apb_prdata_o  <= rdata_next;
            apb_pslverr_o <= err_next;
          end
        end
        BUS_RESP: begin
          bus_state     <= BUS_RECOVER;
          apb_pready_o  <= 1'b0;
          apb_prdata_o  <= '0;
          apb_pslverr_o <= 1'b0;
        end
        default: bus_state <= BUS_IDLE;
      endcase

      if (ctrl_we) begin
        auto_send  <= apb_pwdata_i[0];
        int_enable <= apb_pwdata_i[2];
        invert     <= apb_pwdata_i[3];
      end

      if (index_load)      index <= apb_pwdata_i[AW-1:0];
      else if (index_step) index <= (index == LAST_PIXEL) ? '0 : index + 1'b1;

`ifdef WS2812_BRIGHTNESS_EN
      if (bright_we) brightness <= apb_pwdata_i[7:0];
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (resetn_i && ram_we) colour[index] <= apb_pwdata_i[BITS_PER_LED-1:0];
  end

  // One counter spans a whole bit; the last bit of a pixel ends early so LOAD fits inside BIT_CYC.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      tx_state  <= TX_IDLE;
      pending   <= 1'b0;
      sending   <= 1'b0;
      int_o     <= 1'b0;
      pixel     <= '0;
      shift     <= '0;
      bits_left <= '0;
      cnt       <= '0;
    end else begin
      int_o <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (pending) begin
            tx_state <= TX_LOAD;
            sending  <= 1'b1;
            pixel    <= '0;
          end
        end
        TX_LOAD: begin
          shift     <= colour[pixel];
          bits_left <= 6'(BITS_PER_LED);
          cnt       <= '0;
`ifdef WS2812_BRIGHTNESS_EN
          tx_state  <= TX_SCALE;
`else
          tx_state  <= TX_HIGH;
`endif
        end
`ifdef WS2812_BRIGHTNESS_EN
        TX_SCALE: begin
          shift    <= scale(shift, brightness);
          tx_state <= TX_HIGH;
        end
`endif
        TX_HIGH: begin
          cnt <= cnt + 1'b1;
          if (cnt == (shift[BITS_PER_LED-1] ? T1H_LAST : T0H_LAST)) tx_state <= TX_LOW;
        end
        TX_LOW: begin
          cnt <= cnt + 1'b1;
          if (bits_left != 6'd1) begin
            if (cnt == BIT_LAST) begin
              cnt       <= '0;
              shift     <= shift << 1;
              bits_left <= bits_left - 1'b1;
              tx_state  <= TX_HIGH;
            end
          end else if (pixel != LAST_PIXEL) begin
            if (cnt == BIT_LAST_PIX) begin
              pixel    <= pixel + 1'b1;
              tx_state <= TX_LOAD;
            end
          end else if (cnt == BIT_LAST) begin
            cnt      <= '0;
            tx_state <= TX_GAP;
          end
        end
        TX_GAP: begin
          cnt <= cnt + 1'b1;
          if (cnt == GAP_LAST) begin
            tx_state <= TX_IDLE;
            sending  <= 1'b0;
            int_o    <= int_enable;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase

      // A request coinciding with frame start is covered by that frame's later snapshot.
      if (tx_state == TX_IDLE && pending) pending <= 1'b0;
      else if (set_pending)               pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ws2812_multi_timing_apb.sv
// Directed bench for ws2812_multi_timing_apb with a two-pixel 24-bit chain at default timing.
// Line timing is measured in clock cycles on the negative edge: T0H 13, T1H 26, bit 47, gap 3040.
module tb_ws2812_multi_timing_apb;

  logic        clk = 1'b0;
  logic        resetn;
  logic        led_ctl;
  logic        int_line;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [5:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int   checks = 0;
  int   errors = 0;
  logic late_ready;

  ws2812_multi_timing_apb #(
    .LED_COUNT(2),
    .BITS_PER_LED(24)
  ) dut (
    .clk_i(clk),
    .resetn_i(resetn),
    .led_ctl_o(led_ctl),
    .int_o(int_line),
    .apb_psel_i(psel),
    .apb_penable_i(penable),
    .apb_pwrite_i(pwrite),
    .apb_paddr_i(paddr),
    .apb_pwdata_i(pwdata),
    .apb_prdata_o(prdata),
    .apb_pready_o(pready),
    .apb_pslverr_o(pslverr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic write, input logic [5:0] addr, input logic [31:0] data,
                               output logic [31:0] rdata, output logic err);
    int guard;
    @(negedge clk);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = write;
    paddr   = addr;
    pwdata  = data;
    @(negedge clk);
    penable = 1'b1;
    guard   = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (pready !== 1'b1 && guard < 20);
    checkOutput("apb_pready", 32'(pready), 32'd1);
    rdata   = prdata;
    err     = pslverr;
    psel    = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    late_ready = pready;
  endtask

  task automatic write_reg(input string tag, input logic [5:0] addr, input logic [31:0] data, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    applyStimulus(1'b1, addr, data, rd, err);
    checkOutput({tag, "_pslverr"}, 32'(err), 32'(exp_err));
  endtask

  task automatic read_reg(input string tag, input logic [5:0] addr, input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    applyStimulus(1'b0, addr, 32'd0, rd, err);
    checkOutput({tag, "_prdata"}, rd, exp_data);
    checkOutput({tag, "_pslverr"}, 32'(err), 32'(exp_err));
  endtask

  // Measures one 48-bit frame from its first rising edge through the interrupt pulse (int_enable must be set).
  task automatic captureFrame(input string tag, input logic [47:0] exp_bits, output int start_delay);
    int hi, lo, bad_high, bad_period, width;
    bad_high    = 0;
    bad_period  = 0;
    start_delay = 0;
    lo          = 0;
    while (led_ctl !== 1'b1 && start_delay < 400) begin
      @(negedge clk);
      start_delay++;
    end
    checkOutput({tag, "_start"}, 32'(led_ctl), 32'd1);
    for (int b = 0; b < 48; b++) begin
      hi = 0;
      while (led_ctl === 1'b1 && hi < 100) begin
        @(negedge clk);
        hi++;
      end
      if (hi != (exp_bits[47-b] ? 26 : 13)) bad_high++;
      lo = 0;
      if (b < 47) begin
        while (led_ctl === 1'b0 && lo < 100) begin
          @(negedge clk);
          lo++;
        end
        if (hi + lo != 47) bad_period++;
      end else begin
        while (led_ctl === 1'b0 && int_line === 1'b0 && lo < 4000) begin
          @(negedge clk);
          lo++;
        end
      end
    end
    checkOutput({tag, "_high_times"}, 32'(bad_high), 32'd0);
    checkOutput({tag, "_periods"}, 32'(bad_period), 32'd0);
    checkOutput({tag, "_last_low"}, 32'(lo), exp_bits[0] ? 32'd3061 : 32'd3074);
    width = 0;
    while (int_line === 1'b1 && width < 10) begin
      @(negedge clk);
      width++;
    end
    checkOutput({tag, "_int_width"}, 32'(width), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int delay;
    int highs;
    int guard;
    resetn  = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    late_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_led", 32'(led_ctl), 32'd0);
    checkOutput("rst_int", 32'(int_line), 32'd0);
    checkOutput("rst_prdata", prdata, 32'd0);
    checkOutput("rst_pready", 32'(pready), 32'd0);
    checkOutput("rst_pslverr", 32'(pslverr), 32'd0);
    resetn = 1'b1;
    read_reg("rst_status", 6'h00, 32'h0, 1'b0);
    checkOutput("pready_width", 32'(late_ready), 32'd0);
    read_reg("rst_control", 6'h04, 32'h1, 1'b0);
    read_reg("rst_index", 6'h08, 32'h0, 1'b0);

    // Single frame started by an explicit send
    write_reg("c_int", 6'h04, 32'h4, 1'b0);
    write_reg("idx0", 6'h08, 32'h0, 1'b0);
    write_reg("data0", 6'h0C, 32'h00800001, 1'b0);
    write_reg("data1", 6'h0C, 32'h00000000, 1'b0);
    write_reg("send", 6'h04, 32'h6, 1'b0);
    captureFrame("frame1", {24'h800001, 24'h000000}, delay);
    read_reg("status_after", 6'h00, 32'h0, 1'b0);
    write_reg("status_wr", 6'h00, 32'h1, 1'b1);

    // Mid-frame writes: pixel 0 already latched, pixel 1 not yet; one collapsed re-send
    write_reg("send_auto", 6'h04, 32'h7, 1'b0);
    fork
      captureFrame("frame_a", {24'h800001, 24'h0000F0}, delay);
      begin
        repeat (100) @(negedge clk);
        write_reg("mid_data0", 6'h0C, 32'h0000FF00, 1'b0);
        write_reg("mid_data1", 6'h0C, 32'h000000F0, 1'b0);
        read_reg("mid_status", 6'h00, 32'h3, 1'b0);
      end
    join
    captureFrame("frame_b", {24'h00FF00, 24'h0000F0}, delay);
    checkOutput("resend_start", 32'(delay), 32'd1);
    highs = 0;
    repeat (4000) begin
      @(negedge clk);
      if (led_ctl === 1'b1) highs++;
    end
    checkOutput("no_third_frame", 32'(highs), 32'd0);
    read_reg("status_idle", 6'h00, 32'h0, 1'b0);

    // Pointer wrap and error responses
    write_reg("idx1", 6'h08, 32'h1, 1'b0);
    read_reg("rd_pix1", 6'h0C, 32'h000000F0, 1'b0);
    read_reg("rd_pix0", 6'h0C, 32'h0000FF00, 1'b0);
    write_reg("idx_bad", 6'h08, 32'h2, 1'b1);
    read_reg("idx_kept", 6'h08, 32'h1, 1'b0);
    read_reg("bad_addr", 6'h14, 32'h0, 1'b1);

`ifdef WS2812_BRIGHTNESS_EN
    read_reg("bright_rst", 6'h10, 32'hFF, 1'b0);
    write_reg("b_ctl", 6'h04, 32'h4, 1'b0);
    write_reg("b_idx", 6'h08, 32'h0, 1'b0);
    write_reg("b_data0", 6'h0C, 32'h00FF0080, 1'b0);
    write_reg("b_data1", 6'h0C, 32'h00000000, 1'b0);
    write_reg("b_level", 6'h10, 32'h7F, 1'b0);
    write_reg("b_send", 6'h04, 32'h6, 1'b0);
    captureFrame("bright", {24'h7F0040, 24'h000000}, delay);
`else
    read_reg("bright_absent", 6'h10, 32'h0, 1'b1);
`endif

    // Output invert applies in IDLE
    write_reg("inv_on", 6'h04, 32'h9, 1'b0);
    checkOutput("invert_idle_on", 32'(led_ctl), 32'd1);
    write_reg("inv_off", 6'h04, 32'h1, 1'b0);
    checkOutput("invert_idle_off", 32'(led_ctl), 32'd0);

    // Reset pulse during a HIGH phase
    write_reg("rst_send", 6'h04, 32'h7, 1'b0);
    guard = 0;
    while (led_ctl !== 1'b1 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rst_frame_high", 32'(led_ctl), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    checkOutput("midrst_led", 32'(led_ctl), 32'd0);
    checkOutput("midrst_int", 32'(int_line), 32'd0);
    resetn = 1'b1;
    read_reg("midrst_status", 6'h00, 32'h0, 1'b0);
    read_reg("midrst_control", 6'h04, 32'h1, 1'b0);
    highs = 0;
    repeat (200) begin
      @(negedge clk);
      if (led_ctl === 1'b1) highs++;
    end
    checkOutput("midrst_quiet", 32'(highs), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
